// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file: default parameter
// values and the clear-sequencer state encoding.
package rf_pkg;

    localparam int RF_WIDTH    = 32;
    localparam int RF_DEPTH    = 32;
    localparam int RF_REG_ADDR = 5;
    localparam int RF_NRD      = 2;
    localparam int RF_ZERO_REG = 1;
    localparam int RF_BYPASS   = 1;

    // Clear sequencer states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array data, same-cycle write forwarding
// (port B over port A) and hard-zero register 0.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int REG_ADDR = RF_REG_ADDR,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter int BYPASS   = RF_BYPASS
) (
    input  logic [REG_ADDR-1:0] ra,
    input  logic [WIDTH-1:0]    arr_data,
    input  logic                wa_ok,
    input  logic [REG_ADDR-1:0] waa,
    input  logic [WIDTH-1:0]    wda,
    input  logic                wb_ok,
    input  logic [REG_ADDR-1:0] wab,
    input  logic [WIDTH-1:0]    wdb,
    output logic [WIDTH-1:0]    rd
);

    // wa_ok/wb_ok already fold in legality and the idle-only condition,
    // so a match here is always a write that will actually commit.
    always_comb begin
        rd = arr_data;
        if (BYPASS != 0) begin
            if (wb_ok && (wab == ra)) begin
                rd = wdb;
            end else if (wa_ok && (waa == ra)) begin
                rd = wda;
            end
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Register file with NRD combinational read ports, two write ports
// (B wins on collision) and a one-register-per-cycle sequential clear.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int REG_ADDR = RF_REG_ADDR,
    parameter int NRD      = RF_NRD,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter int BYPASS   = RF_BYPASS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NRD*REG_ADDR-1:0] RA,
    output logic [NRD*WIDTH-1:0]    RD,
    input  logic                    WEA,
    input  logic [REG_ADDR-1:0]     WAA,
    input  logic [WIDTH-1:0]        WDA,
    input  logic                    WEB,
    input  logic [REG_ADDR-1:0]     WAB,
    input  logic [WIDTH-1:0]        WDB,
    input  logic                    CLR,
    output logic                    BUSY
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             wa_ok;
    logic             wb_ok;

    assign BUSY = (state == ST_CLEAR);

    // Qualified write enables: idle only, in range, never register 0 when hard-zeroed
    always_comb begin
        wa_ok = WEA && (state == ST_IDLE) && (32'(WAA) < DEPTH)
                && !((ZERO_REG != 0) && (WAA == '0));
        wb_ok = WEB && (state == ST_IDLE) && (32'(WAB) < DEPTH)
                && !((ZERO_REG != 0) && (WAB == '0));
    end

    // Clear sequencer: CLR starts a DEPTH-cycle sweep, ignored while sweeping
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CLR) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Storage: async zero, sweep-clear in CLEAR, else A then B so B wins
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem <= '{default: '0};
        end else if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wa_ok) mem[WAA] <= WDA;
            if (wb_ok) mem[WAB] <= WDB;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [REG_ADDR-1:0] ra_k;
        logic [WIDTH-1:0]    arr_k;

        assign ra_k  = RA[k*REG_ADDR +: REG_ADDR];
        assign arr_k = (32'(ra_k) < DEPTH) ? mem[ra_k] : '0;

        rf_read_port #(
            .WIDTH    (WIDTH),
            .REG_ADDR (REG_ADDR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .ra       (ra_k),
            .arr_data (arr_k),
            .wa_ok    (wa_ok),
            .waa      (WAA),
            .wda      (WDA),
            .wb_ok    (wb_ok),
            .wab      (WAB),
            .wdb      (WDB),
            .rd       (RD[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: default instance (32x32, 2 read ports)
// plus a 20-deep, 4-read-port instance, both checked against an array model.
module tb_multiport_register_file;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // Instance 1: defaults
    logic [9:0]  ra1;
    logic [63:0] rd1;
    logic        wea1, web1, clr1, busy1;
    logic [4:0]  waa1, wab1;
    logic [31:0] wda1, wdb1;

    // Instance 2: NRD=4, DEPTH=20
    logic [19:0]  ra2;
    logic [127:0] rd2;
    logic         wea2, web2, clr2, busy2;
    logic [4:0]   waa2, wab2;
    logic [31:0]  wda2, wdb2;

    multiport_register_file dut1 (
        .CLK(CLK), .RST(RST), .RA(ra1), .RD(rd1),
        .WEA(wea1), .WAA(waa1), .WDA(wda1),
        .WEB(web1), .WAB(wab1), .WDB(wdb1),
        .CLR(clr1), .BUSY(busy1)
    );

    multiport_register_file #(.NRD(4), .DEPTH(20)) dut2 (
        .CLK(CLK), .RST(RST), .RA(ra2), .RD(rd2),
        .WEA(wea2), .WAA(waa2), .WDA(wda2),
        .WEB(web2), .WAB(wab2), .WDB(wdb2),
        .CLR(clr2), .BUSY(busy2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] m1 [32];
    logic [31:0] m2 [32];
    bit          mb1;
    int          mi1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m1[i] = '0;
            m2[i] = '0;
        end
        mb1 = 1'b0;
        mi1 = 0;
    endtask

    // Expected read value from the rules: out of range or reg 0 -> 0,
    // forwarding of a pending legal write when not clearing (B over A).
    function automatic logic [31:0] exp_rd(input int which, input logic [4:0] a);
        int depth;
        bit busy;
        logic we_a, we_b;
        logic [4:0] aa, ab;
        logic [31:0] da, db;
        depth = (which == 1) ? 32 : 20;
        busy  = (which == 1) ? mb1 : 1'b0;
        we_a = (which == 1) ? wea1 : wea2;
        we_b = (which == 1) ? web1 : web2;
        aa   = (which == 1) ? waa1 : waa2;
        ab   = (which == 1) ? wab1 : wab2;
        da   = (which == 1) ? wda1 : wda2;
        db   = (which == 1) ? wdb1 : wdb2;
        if (int'(a) >= depth || a == 5'd0) return '0;
        if (!busy) begin
            if (we_b && ab == a) return db;
            if (we_a && aa == a) return da;
        end
        return (which == 1) ? m1[a] : m2[a];
    endfunction

    task automatic model_edge();
        if (mb1) begin
            m1[mi1] = '0;
            if (mi1 == 31) mb1 = 1'b0;
            else mi1++;
        end else begin
            if (clr1) begin
                mb1 = 1'b1;
                mi1 = 0;
            end
            if (wea1 && waa1 != 5'd0) m1[waa1] = wda1;
            if (web1 && wab1 != 5'd0) m1[wab1] = wdb1;
        end
        if (wea2 && waa2 != 5'd0 && int'(waa2) < 20) m2[waa2] = wda2;
        if (web2 && wab2 != 5'd0 && int'(wab2) < 20) m2[wab2] = wdb2;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++)
            chk($sformatf("dut1 rd%0d ra=%0d", k, ra1[k*5 +: 5]), rd1[k*32 +: 32], exp_rd(1, ra1[k*5 +: 5]));
        chk("dut1 busy", {31'd0, busy1}, {31'd0, mb1});
        for (int k = 0; k < 4; k++)
            chk($sformatf("dut2 rd%0d ra=%0d", k, ra2[k*5 +: 5]), rd2[k*32 +: 32], exp_rd(2, ra2[k*5 +: 5]));
        chk("dut2 busy", {31'd0, busy2}, 32'd0);
    endtask

    // One cycle: check at the falling edge, advance the model at the rising edge
    task automatic step();
        @(negedge CLK);
        check_outputs();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    task automatic idle_inputs();
        wea1 = 0; web1 = 0; clr1 = 0;
        wea2 = 0; web2 = 0; clr2 = 0;
    endtask

    int busy_cnt;

    initial begin
        RST = 1'b0;
        ra1 = '0; ra2 = '0;
        waa1 = '0; wab1 = '0; wda1 = '0; wdb1 = '0;
        waa2 = '0; wab2 = '0; wda2 = '0; wdb2 = '0;
        idle_inputs();
        model_reset();

        // Reset state: every address reads 0, BUSY low
        #1;
        for (int a = 0; a < 32; a++) begin
            ra1 = {5'(a), 5'(a)};
            ra2 = {4{5'(a)}};
            #1;
            chk($sformatf("reset rd1 a=%0d", a), rd1[31:0], 32'd0);
            chk($sformatf("reset rd2 a=%0d", a), rd2[127:96], 32'd0);
        end
        chk("reset busy", {31'd0, busy1}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Write then read back next cycle
        wea1 = 1; waa1 = 5'd3; wda1 = 32'hDEADBEEF; ra1 = {5'd0, 5'd3};
        step();
        wea1 = 0;
        #1;
        chk("wr3 readback", rd1[31:0], 32'hDEADBEEF);
        step();

        // A/B collision: B stored, and forwarded in the same cycle
        wea1 = 1; waa1 = 5'd5; wda1 = 32'h11;
        web1 = 1; wab1 = 5'd5; wdb1 = 32'h22;
        ra1 = {5'd5, 5'd3};
        #1;
        chk("collide bypass", rd1[63:32], 32'h22);
        step();
        idle_inputs();
        #1;
        chk("collide stored", rd1[63:32], 32'h22);
        step();

        // Register 0 stays zero, even under bypass
        web1 = 1; wab1 = 5'd0; wdb1 = 32'hFFFFFFFF; ra1 = '0;
        #1;
        chk("zero reg bypass", rd1[31:0], 32'd0);
        step();
        web1 = 0;
        #1;
        chk("zero reg after", rd1[31:0], 32'd0);
        step();

        // Randomized traffic, including occasional clears
        for (int n = 0; n < 300; n++) begin
            wea1 = 1'($urandom); waa1 = rand_addr(); wda1 = $urandom;
            web1 = 1'($urandom); wab1 = rand_addr(); wdb1 = $urandom;
            clr1 = ($urandom % 40) == 0;
            ra1  = {rand_addr(), rand_addr()};
            wea2 = 1'($urandom); waa2 = rand_addr(); wda2 = $urandom;
            web2 = 1'($urandom); wab2 = rand_addr(); wdb2 = $urandom;
            ra2  = {rand_addr(), rand_addr(), rand_addr(), rand_addr()};
            step();
        end
        idle_inputs();
        for (int n = 0; n < 40 && mb1; n++) step();

        // Fill 1..31 with index, clear, BUSY exactly 32 cycles, writes/CLR ignored
        for (int i = 1; i < 32; i++) begin
            wea1 = 1; waa1 = 5'(i); wda1 = 32'(i); ra1 = {5'(i), 5'(i - 1)};
            step();
        end
        wea1 = 0;
        clr1 = 1;
        step();
        clr1 = 0;
        busy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            wea1 = mb1 ? 1'b1 : 1'b0;
            waa1 = 5'($urandom_range(1, 31)); wda1 = $urandom;
            clr1 = mb1 ? 1'($urandom) : 1'b0;
            ra1 = {waa1, 5'($urandom_range(0, 31))};
            #1;
            if (busy1) busy_cnt++;
            step();
        end
        idle_inputs();
        chk("clear busy cycles", 32'(busy_cnt), 32'd32);
        for (int a = 0; a < 32; a++) begin
            ra1 = {5'(a), 5'(a)};
            #1;
            chk($sformatf("cleared a=%0d", a), rd1[31:0], 32'd0);
        end

        // Reset in the middle of a clear
        for (int i = 20; i < 32; i++) begin
            wea1 = 1; waa1 = 5'(i); wda1 = 32'hA500 + 32'(i);
            step();
        end
        wea1 = 0;
        clr1 = 1;
        step();
        clr1 = 0;
        for (int n = 0; n < 10; n++) step();
        RST = 1'b0;
        #1;
        model_reset();
        chk("abort busy", {31'd0, busy1}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            ra1 = {5'(a), 5'(a)};
            #1;
            chk($sformatf("abort reg a=%0d", a), rd1[31:0], 32'd0);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        clr1 = 1;
        step();
        clr1 = 0;
        busy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (busy1) busy_cnt++;
            step();
        end
        chk("second clear cycles", 32'(busy_cnt), 32'd32);

        // DEPTH=20 instance: out-of-range read and write
        for (int i = 1; i < 20; i++) begin
            wea2 = 1; waa2 = 5'(i); wda2 = $urandom;
            step();
        end
        wea2 = 1; waa2 = 5'd25; wda2 = 32'h5A5A5A5A;
        ra2 = {4{5'd25}};
        #1;
        chk("dut2 read 25 bypass", rd2[31:0], 32'd0);
        step();
        wea2 = 0;
        for (int base = 0; base < 32; base += 4) begin
            ra2 = {5'(base + 3), 5'(base + 2), 5'(base + 1), 5'(base)};
            step();
        end
        ra2 = {4{5'd25}};
        #1;
        chk("dut2 read 25", rd2[127:96], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (2..2**REG_ADDR).
REQ-003 SHALL have parameter REG_ADDR, default 5, address width.
REQ-004 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-006 SHALL have parameter BYPASS, default 1; when 1, same-cycle writes forward to reads.
REQ-007 CLK  input  1  clock, rising edge.
REQ-008 RST  input  1  reset, asynchronous, active-low.
REQ-009 RA  input  NRD*REG_ADDR  read addresses, port k at bits [k*REG_ADDR +: REG_ADDR].
REQ-010 RD  output  NRD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH].
REQ-011 WEA, WAA, WDA  input  1/REG_ADDR/WIDTH  write port A enable/address/data.
REQ-012 WEB, WAB, WDB  input  1/REG_ADDR/WIDTH  write port B enable/address/data.
REQ-013 CLR  input  1  synchronous request to start a sequential clear of all registers.
REQ-014 BUSY  output  1  high while a sequential clear is in progress.

Function
REQ-015 Reads SHALL be combinational: RD[k] reflects array contents at RA[k] in the same cycle.
REQ-016 Writes SHALL commit on the rising CLK edge; the written value is visible on RD from the following cycle.
REQ-017 WEA and WEB to the same address in one cycle: port B value SHALL be stored.
REQ-018 Write address >= DEPTH SHALL be ignored; read address >= DEPTH SHALL return 0.
REQ-019 ZERO_REG=1: writes to address 0 dropped; any read of address 0 returns 0, including under bypass.
REQ-020 BYPASS=1 and FSM IDLE: a read matching an enabled, legal write address in the same cycle SHALL return that write data, port B taking priority over A.
REQ-021 FSM states: IDLE, CLEAR; reset state IDLE.
REQ-022 IDLE -> CLEAR on CLK edge with CLR=1; clear index counter loads 0.
REQ-023 In CLEAR, one register per cycle SHALL be zeroed (index 0,1,...,DEPTH-1); CLEAR -> IDLE on the edge that clears index DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-024 BUSY SHALL equal 1 exactly while state is CLEAR (registered, no combinational path from CLR).
REQ-025 In CLEAR, WEA/WEB SHALL be ignored, bypass disabled, and reads return the current array contents.
REQ-026 CLR asserted while in CLEAR SHALL be ignored; the clear does not restart.
REQ-027 Clear counter width SHALL be $clog2(DEPTH), with no wrap beyond DEPTH-1.

Reset
REQ-028 RST low SHALL asynchronously zero all registers, set state IDLE, counter 0, BUSY 0.
REQ-029 RST asserted mid-CLEAR SHALL abort the clear; after release, state is IDLE with all registers 0.
REQ-030 After reset, all RD outputs SHALL read 0 for every address.

Structure
REQ-031 State encoding (IDLE/CLEAR) and default parameter values SHALL reside in shared package rf_pkg.
REQ-032 The per-port read/bypass mux SHALL be one sub-module, rf_read_port, instantiated NRD times via generate.

Verification
REQ-033 Reset, WEA=1 WAA=3 WDA=0xDEADBEEF; next cycle RA port0=3 -> RD port0=0xDEADBEEF.
REQ-034 WEA WAA=5 WDA=0x11, WEB WAB=5 WDB=0x22 same cycle -> reg5=0x22; with BYPASS=1, same-cycle read of 5 returns 0x22.
REQ-035 ZERO_REG=1, WEB WAB=0 WDB=0xFFFFFFFF -> RD of address 0 is 0 in that cycle and after.
REQ-036 Fill regs 1..31 with index value, pulse CLR -> BUSY high exactly 32 cycles, WEA during CLEAR ignored, all regs 0 afterwards.
REQ-037 RST low at cycle 10 of CLEAR -> BUSY 0 immediately, all regs 0, second CLR after release runs full DEPTH cycles.
REQ-038 NRD=4, DEPTH=20: read address 25 -> 0; write to 25 -> no register changes.
